// File: rtl/sampletest_hs_pkg.sv
// sampletest_hs_pkg: shared raster types and width helpers
package sampletest_hs_pkg;
  localparam int TRI_VERTS = 3;
  typedef enum logic [1:0] {
    CULL_NONE  = 2'd0,
    CULL_BACK  = 2'd1,
    CULL_FRONT = 2'd2
  } cull_mode_t;
  function automatic int edge_w(input int sigfig, input int trunc);
    return 2 * (sigfig - trunc);
  endfunction
endpackage

// File: rtl/sampletest_hs_edge_eval.sv
// sampletest_hs_edge_eval: one lane's truncated edge functions and cull-aware hit decision
module sampletest_hs_edge_eval
  import sampletest_hs_pkg::*;
#(
  parameter int SIGFIG = 24,
  parameter int TRUNC  = 7
) (
  input  logic [TRI_VERTS-1:0][SIGFIG-TRUNC-1:0] vx,
  input  logic [TRI_VERTS-1:0][SIGFIG-TRUNC-1:0] vy,
  input  logic [SIGFIG-TRUNC-1:0]                sx,
  input  logic [SIGFIG-TRUNC-1:0]                sy,
  input  logic                                   samp_valid,
  input  cull_mode_t                             mode,
  output logic                                   hit
);
  localparam int TW = SIGFIG - TRUNC;
  localparam int EW = edge_w(SIGFIG, TRUNC);
  logic signed [TW-1:0] x [TRI_VERTS];
  logic signed [TW-1:0] y [TRI_VERTS];
  logic signed [EW-1:0] d [TRI_VERTS];
  logic neg, pos;
  // Only the low TW bits of the shift matter, so subtract at that width directly
  always_comb begin
    for (int i = 0; i < TRI_VERTS; i++) begin
      x[i] = vx[i] - sx;
      y[i] = vy[i] - sy;
    end
    for (int i = 0; i < TRI_VERTS; i++)
      d[i] = x[i] * y[(i + 1) % TRI_VERTS] - x[(i + 1) % TRI_VERTS] * y[i];
    neg = d[0] <= 0 && d[1] < 0 && d[2] <= 0;
    pos = d[0] >= 0 && d[1] > 0 && d[2] >= 0;
    hit = samp_valid && (mode == CULL_FRONT ? pos : mode == CULL_NONE ? (neg || pos) : neg);
  end
endmodule

// File: rtl/sampletest_hs.sv
// sampletest_hs: multi-sample triangle test with valid/ready pipeline and saturating hit counter
module sampletest_hs
  import sampletest_hs_pkg::*;
#(
  parameter int SIGFIG     = 24,
  parameter int RADIX      = 10,
  parameter int VERTS      = 3,
  parameter int AXIS       = 3,
  parameter int COLORS     = 3,
  parameter int SAMPLES    = 4,
  parameter int TRUNC      = 7,
  parameter int PIPE_DEPTH = 2,
  parameter int CNT_W      = 32
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]      tri_in,
  input  logic [COLORS-1:0][SIGFIG-1:0]               color_in,
  input  logic [SAMPLES-1:0][1:0][SIGFIG-1:0]         sample_in,
  input  logic [SAMPLES-1:0]                          samp_valid_in,
  input  logic [1:0]                                  cull_mode_in,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  output logic [SAMPLES-1:0][AXIS-1:0][SIGFIG-1:0]    hit_out,
  output logic [COLORS-1:0][SIGFIG-1:0]               color_out,
  output logic [SAMPLES-1:0]                          hit_mask_out,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  input  logic                                        clear_count,
  output logic [CNT_W-1:0]                            hit_count
);
  localparam int TW  = SIGFIG - TRUNC;
  localparam int PW  = SAMPLES + SAMPLES * AXIS * SIGFIG + COLORS * SIGFIG;
  localparam int PCW = $clog2(SAMPLES + 1);
  if (VERTS != TRI_VERTS || AXIS != 3 || SAMPLES < 1 || SAMPLES > 16 || PIPE_DEPTH < 1 || RADIX >= SIGFIG) begin : g_bad
    $error("sampletest_hs: unsupported parameter set");
  end
  logic [SAMPLES-1:0] hit_c;
  logic [SAMPLES-1:0][AXIS-1:0][SIGFIG-1:0] pos_c;
  for (genvar j = 0; j < SAMPLES; j++) begin : g_lane
    sampletest_hs_edge_eval #(.SIGFIG(SIGFIG), .TRUNC(TRUNC)) u_edge (
      .vx({tri_in[2][0][TW-1:0], tri_in[1][0][TW-1:0], tri_in[0][0][TW-1:0]}),
      .vy({tri_in[2][1][TW-1:0], tri_in[1][1][TW-1:0], tri_in[0][1][TW-1:0]}),
      .sx(sample_in[j][0][TW-1:0]),
      .sy(sample_in[j][1][TW-1:0]),
      .samp_valid(samp_valid_in[j]),
      .mode(cull_mode_t'(cull_mode_in)),
      .hit(hit_c[j])
    );
    assign pos_c[j] = {tri_in[0][2], sample_in[j][1], sample_in[j][0]};
  end
  logic [PIPE_DEPTH-1:0] vld_q, vld_d, load;
  logic [PIPE_DEPTH:0]   vsrc;
  logic [PW-1:0]         data_q [PIPE_DEPTH];
  logic [PW-1:0]         data_d [PIPE_DEPTH];
  logic [PW-1:0]         src [PIPE_DEPTH+1];
  logic                  ld;
  // A stage loads when it, or any stage downstream of it, can make room this cycle
  always_comb begin
    ld = out_ready;
    load = '0;
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      ld = ld || !vld_q[k];
      load[k] = ld;
    end
    vsrc = {vld_q, in_valid};
    src[0] = {color_in, pos_c, hit_c};
    for (int k = 0; k < PIPE_DEPTH; k++) src[k+1] = data_q[k];
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      vld_d[k] = load[k] ? vsrc[k] : vld_q[k];
      data_d[k] = load[k] ? src[k] : data_q[k];
    end
  end
  assign in_ready = load[0];
  assign out_valid = vld_q[PIPE_DEPTH-1];
  assign {color_out, hit_out, hit_mask_out} = data_q[PIPE_DEPTH-1];
  logic [PCW-1:0]   pc;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fire;
  always_comb begin
    pc = '0;
    for (int k = 0; k < SAMPLES; k++) pc = pc + PCW'(hit_mask_out[k]);
    fire = out_valid && out_ready;
    sum = {1'b0, cnt_q} + (CNT_W+1)'(pc);
    cnt_d = clear_count ? (fire ? CNT_W'(pc) : '0) : !fire ? cnt_q : sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end
  assign hit_count = cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      cnt_q <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) data_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      for (int k = 0; k < PIPE_DEPTH; k++) data_q[k] <= data_d[k];
    end
  end
endmodule
